// File: rtl/stream_arb_mux_if.sv
// Valid/ready stream bundle with a data beat and end-of-packet marker.
interface stream_intf #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport source (output valid, output data, output last, input ready);
    modport sink   (input valid, input data, input last, output ready);
endinterface

// File: rtl/stream_arb_mux.sv
// N-channel round-robin stream arbiter/mux with a single registered output stage.
// Define STREAM_ARB_MUX_PKT_LOCK_EN to hold the grant on one channel until its packet ends.
module stream_arb_mux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N > 1 ? N : 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_intf.sink      ins [N-1:0],
    stream_intf.source    out,
    output logic [IW-1:0] grant_idx,
    output logic          busy
);

    logic [N-1:0]  valid_s;
    logic [N-1:0]  last_s;
    logic [N-1:0]  ready_s;
    logic [W-1:0]  data_s [N];

    logic          full_r;
    logic [W-1:0]  data_r;
    logic          last_r;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] ptr_r;

    logic          load_s;
    logic          any_s;
    logic [IW-1:0] rr_sel_s;
    logic [IW-1:0] sel_s;
    logic          xfer_s;
    logic          grant_ok_s;

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign valid_s[k]   = ins[k].valid;
        assign data_s[k]    = ins[k].data;
        assign last_s[k]    = ins[k].last;
        assign ins[k].ready = ready_s[k];
    end

    assign load_s = !full_r || out.ready;
    assign any_s  = |valid_s;

    // Round-robin pick: lowest valid channel above ptr wins, else lowest at or below ptr.
    always_comb begin
        rr_sel_s = {IW{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            rr_sel_s = (valid_s[k] && (k <= int'(ptr_r))) ? IW'(k) : rr_sel_s;
        end
        for (int k = N - 1; k >= 0; k--) begin
            rr_sel_s = (valid_s[k] && (k > int'(ptr_r))) ? IW'(k) : rr_sel_s;
        end
    end

`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
    logic          locked_r;
    logic [IW-1:0] lock_idx_r;

    // While locked, the owning channel keeps the grant even when it is momentarily idle.
    always_comb begin
        sel_s      = locked_r ? lock_idx_r : rr_sel_s;
        xfer_s     = load_s && (locked_r ? valid_s[lock_idx_r] : any_s);
        grant_ok_s = load_s && (locked_r || any_s);
    end

    // Packet lock tracking: open on a non-last beat, close on the closing beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_r   <= 1'b0;
            lock_idx_r <= {IW{1'b0}};
        end else if (xfer_s) begin
            if (!last_s[sel_s]) begin
                locked_r   <= 1'b1;
                lock_idx_r <= sel_s;
            end else begin
                locked_r   <= 1'b0;
            end
        end
    end
`else
    // Per-beat arbitration: no state beyond the round-robin pointer.
    always_comb begin
        sel_s      = rr_sel_s;
        xfer_s     = load_s && any_s;
        grant_ok_s = xfer_s;
    end
`endif

    // One-hot ready toward the selected channel only.
    always_comb begin
        ready_s = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            ready_s[k] = grant_ok_s && (sel_s == IW'(k));
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            data_r <= {W{1'b0}};
            last_r <= 1'b0;
            idx_r  <= {IW{1'b0}};
            ptr_r  <= IW'(N - 1);
        end else if (xfer_s) begin
            full_r <= 1'b1;
            data_r <= data_s[sel_s];
            last_r <= last_s[sel_s];
            idx_r  <= sel_s;
            ptr_r  <= sel_s;
        end else if (out.ready) begin
            full_r <= 1'b0;
        end
    end

    assign out.valid = full_r;
    assign out.data  = data_r;
    assign out.last  = last_r;
    assign grant_idx = idx_r;
    assign busy      = full_r;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux (N=4/W=8 instance plus an N=1/W=32 instance).
module tb_stream_arb_mux;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [N-1:0] drv_v, drv_l;
    logic [W-1:0] drv_d [N];
    logic         drv_ordy;
    wire  [N-1:0] rdy_w;
    logic [1:0]   grant_idx;
    logic         busy;

    stream_intf #(.W(W)) ins_if [N-1:0] ();
    stream_intf #(.W(W)) out_if ();

    for (genvar k = 0; k < N; k++) begin : g_drv
        assign ins_if[k].valid = drv_v[k];
        assign ins_if[k].data  = drv_d[k];
        assign ins_if[k].last  = drv_l[k];
        assign rdy_w[k]        = ins_if[k].ready;
    end
    assign out_if.ready = drv_ordy;

    stream_arb_mux #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins_if), .out(out_if),
        .grant_idx(grant_idx), .busy(busy)
    );

    logic        drv1_v, drv1_ordy;
    logic [31:0] drv1_d;
    logic [0:0]  grant1;
    logic        busy1;
    stream_intf #(.W(32)) ins1_if [0:0] ();
    stream_intf #(.W(32)) out1_if ();
    assign ins1_if[0].valid = drv1_v;
    assign ins1_if[0].data  = drv1_d;
    assign ins1_if[0].last  = 1'b1;
    assign out1_if.ready    = drv1_ordy;

    stream_arb_mux #(.N(1), .W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .ins(ins1_if), .out(out1_if),
        .grant_idx(grant1), .busy(busy1)
    );

    // Reference model state and scoreboard
    beat_t exp_q[$];
    int    ptr_m, lock_idx_m;
    bit    full_m, locked_m;
    int    n_cmp = 0;
    int    n_bad = 0;

    logic [N-1:0] obs_rdy, exp_rdy;
    logic         obs_valid, exp_valid, obs_last;
    logic [7:0]   obs_data;
    logic [1:0]   obs_idx;
    beat_t        exp_beat;
    int           trans_idx;

    task automatic model_reset();
        ptr_m = N - 1; full_m = 1'b0; locked_m = 1'b0; lock_idx_m = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; drv_v = '0; drv_l = '1; drv_ordy = 1'b0; drv1_v = 1'b0; drv1_ordy = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge with inputs driven; samples DUT, predicts, advances one clock.
    task automatic step();
        int sel; bit any; bit load; bit okr; bit xfer; beat_t b;
        #1;
        obs_rdy = rdy_w; obs_valid = out_if.valid; obs_data = out_if.data;
        obs_idx = grant_idx; obs_last = out_if.last;
        load = !full_m || drv_ordy;
        sel = -1;
        for (int i = 1; i <= N; i++)
            if (sel < 0 && drv_v[(ptr_m + i) % N]) sel = (ptr_m + i) % N;
        any = (sel >= 0);
        okr = load && any;
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
        if (locked_m) begin
            sel = lock_idx_m; any = drv_v[sel]; okr = load;
        end
`endif
        xfer = load && any;
        exp_rdy = okr ? (4'b0001 << sel) : 4'b0000;
        exp_valid = full_m;
        exp_beat = full_m ? exp_q[0] : '0;
        if (full_m && drv_ordy) void'(exp_q.pop_front());
        trans_idx = -1;
        if (xfer) begin
            b.idx = 2'(sel); b.data = drv_d[sel]; b.last = drv_l[sel];
            exp_q.push_back(b);
            ptr_m = sel; full_m = 1'b1; trans_idx = sel;
            if (!drv_l[sel]) begin locked_m = 1'b1; lock_idx_m = sel; end
            else locked_m = 1'b0;
        end else if (drv_ordy) begin
            full_m = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp += 6;
        if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", out_if.valid); end
        if (out_if.data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h expected 00", out_if.data); end
        if (out_if.last !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b expected 0", out_if.last); end
        if (grant_idx !== 2'd0) begin n_bad++; $display("FAIL rst_grant: got %0d expected 0", grant_idx); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (out1_if.valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid_n1: got %b expected 0", out1_if.valid); end
    endtask

    task automatic test_single_channel();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        apply_reset();
        drv_ordy = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            drv_v = (i < 3) ? 4'b0100 : 4'b0000;
            drv_d[2] = (i < 3) ? vals[i] : 8'h00;
            step();
            n_cmp += 2;
            if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL single_rdy: got %b expected %b", obs_rdy, exp_rdy); end
            if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL single_valid: got %b expected %b", obs_valid, exp_valid); end
            if (i > 0) begin
                n_cmp += 2;
                if (obs_data !== vals[i-1]) begin n_bad++; $display("FAIL single_data: got %h expected %h", obs_data, vals[i-1]); end
                if (obs_idx !== 2'd2) begin n_bad++; $display("FAIL single_grant: got %0d expected 2", obs_idx); end
            end
        end
    endtask

    task automatic test_round_robin();
        int cnt [N];
        apply_reset();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        drv_ordy = 1'b1; drv_v = 4'hF; drv_l = 4'hF;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < N; k++) drv_d[k] = 8'(k * 64 + (i % 64));
            step();
            n_cmp += 3;
            if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL rr_rdy: got %b expected %b", obs_rdy, exp_rdy); end
            if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL rr_valid: got %b expected %b", obs_valid, exp_valid); end
            if (trans_idx !== i % 4) begin n_bad++; $display("FAIL rr_order: got %0d expected %0d", trans_idx, i % 4); end
            if (exp_valid) begin
                n_cmp++;
                if (obs_data !== exp_beat.data || obs_idx !== exp_beat.idx || obs_last !== exp_beat.last)
                begin n_bad++; $display("FAIL rr_beat: got %h/%0d expected %h/%0d", obs_data, obs_idx, exp_beat.data, exp_beat.idx); end
            end
            if (trans_idx >= 0 && obs_rdy[trans_idx] === 1'b1) cnt[trans_idx]++;
        end
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (cnt[k] !== 25) begin n_bad++; $display("FAIL rr_share: ch%0d got %0d expected 25", k, cnt[k]); end
        end
        drv_v = 4'h0;
        step();
        step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        drv_l = 4'hF;
        drv_v = 4'b0001; drv_d[0] = 8'hA5; drv_ordy = 1'b1;
        step();
        drv_ordy = 1'b0; drv_v = 4'hF;
        for (int k = 0; k < N; k++) drv_d[k] = 8'(8'h10 + k);
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp += 3;
            if (obs_data !== 8'hA5) begin n_bad++; $display("FAIL bp_data: got %h expected a5", obs_data); end
            if (obs_rdy !== 4'b0000) begin n_bad++; $display("FAIL bp_rdy: got %b expected 0000", obs_rdy); end
            if (obs_valid !== exp_valid) begin n_bad++; $display("FAIL bp_valid: got %b expected %b", obs_valid, exp_valid); end
        end
        drv_ordy = 1'b1;
        step();
        n_cmp++;
        if (obs_rdy !== 4'b0010) begin n_bad++; $display("FAIL bp_release_rdy: got %b expected 0010", obs_rdy); end
        drv_v = 4'h0;
        step();
        n_cmp += 2;
        if (obs_valid !== 1'b1) begin n_bad++; $display("FAIL bp_bubble: got valid %b expected 1", obs_valid); end
        if (obs_data !== 8'h11) begin n_bad++; $display("FAIL bp_next: got %h expected 11", obs_data); end
        step();
    endtask

    task automatic test_lock();
        int exp_seq [6];
        int b1;
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
        exp_seq = '{0, 1, 1, 1, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
        apply_reset();
        b1 = 0; drv_ordy = 1'b1; drv_l[0] = 1'b1; drv_d[0] = 8'hC0;
        for (int i = 0; i < 6; i++) begin
            drv_v = {2'b00, (b1 < 3), 1'b1};
            drv_d[1] = 8'(8'hB1 + b1);
            drv_l[1] = (b1 == 2);
            step();
            n_cmp += 3;
            if (trans_idx !== exp_seq[i]) begin n_bad++; $display("FAIL lock_order[%0d]: got %0d expected %0d", i, trans_idx, exp_seq[i]); end
            if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL lock_rdy: got %b expected %b", obs_rdy, exp_rdy); end
            if (exp_valid && obs_data !== exp_beat.data) begin n_bad++; $display("FAIL lock_data: got %h expected %h", obs_data, exp_beat.data); end
            if (trans_idx == 1) b1++;
            drv_d[0] = 8'(drv_d[0] + ((trans_idx == 0) ? 1 : 0));
        end
        drv_v = 4'h0;
        step();
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        drv_l = 4'hF; drv_v = 4'b0100; drv_d[2] = 8'h5A; drv_ordy = 1'b0;
        step();
        drv_v = 4'h0;
        #1;
        n_cmp++;
        if (out_if.valid !== 1'b1) begin n_bad++; $display("FAIL mid_full: got %b expected 1", out_if.valid); end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp += 2;
        if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b expected 0", out_if.valid); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
        drv_v = 4'hF; drv_ordy = 1'b1;
        for (int k = 0; k < N; k++) drv_d[k] = 8'(8'h70 + k);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (trans_idx !== 0 || obs_rdy !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got rdy %b expected 0001", obs_rdy); end
        drv_v = 4'h0;
        step();
        n_cmp += 2;
        if (obs_idx !== 2'd0) begin n_bad++; $display("FAIL mid_grant_idx: got %0d expected 0", obs_idx); end
        if (obs_data !== 8'h70) begin n_bad++; $display("FAIL mid_data: got %h expected 70", obs_data); end
        step();
    endtask

    task automatic test_n1();
        logic [31:0] q32 [$];
        logic [31:0] e;
        apply_reset();
        drv1_ordy = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            drv1_v = (i < 5);
            drv1_d = 32'hDEADBEEF + 32'(i);
            #1;
            n_cmp += 2;
            if (ins1_if[0].ready !== (i < 5)) begin n_bad++; $display("FAIL n1_rdy: got %b expected %b", ins1_if[0].ready, (i < 5)); end
            if (out1_if.valid !== (i > 0)) begin n_bad++; $display("FAIL n1_valid: got %b expected %b", out1_if.valid, (i > 0)); end
            if (i > 0) begin
                e = q32.pop_front();
                n_cmp++;
                if (out1_if.data !== e) begin n_bad++; $display("FAIL n1_data: got %h expected %h", out1_if.data, e); end
            end
            if (i < 5) q32.push_back(drv1_d);
            @(posedge clk);
            @(negedge clk);
        end
        drv1_v = 1'b0;
    endtask

    initial begin
        drv_v = '0; drv_l = '1; drv_ordy = 1'b0;
        for (int k = 0; k < N; k++) drv_d[k] = '0;
        drv1_v = 1'b0; drv1_d = '0; drv1_ordy = 1'b0;
        model_reset();
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_reset_midstream();
        test_n1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
